// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: a single-request front end that turns
// requester reads, full writes and byte-masked writes into accesses on a
// synchronous memory port, using read-modify-write for partial writes.
module dmem_access_ctrl #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR-1:0]   req_addr,
  input  logic [WORD-1:0]   req_wdata,
  input  logic [WORD/8-1:0] req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD-1:0]   resp_rdata,
  output logic [ADDR-1:0]   mem_a,
  output logic              mem_w,
  output logic [WORD-1:0]   mem_d,
  input  logic [WORD-1:0]   mem_q
);

  localparam int NBYTE = WORD / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_DATA, WR, RMW_RD, RMW_MERGE, RMW_WR, RESP
  } state_e;

  state_e           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WORD-1:0]  wdata_q, wdata_d;
  logic [NBYTE-1:0] be_q, be_d;
  logic             we_q, we_d;
  logic [WORD-1:0]  merge_q, merge_d;
  logic [WORD-1:0]  rdata_q, rdata_d;
  logic [WORD-1:0]  mem_d_q;

  assign mem_a      = addr_q;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

  // Next-state, request acceptance and datapath-register update logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    mem_w     = 1'b0;
    mem_d     = mem_d_q;

    case (state_q)
      IDLE:      req_ready = 1'b1;
      RD_ISSUE:  state_d = RD_DATA;
      RD_DATA: begin
        rdata_d = we_q ? '0 : mem_q;
        state_d = RESP;
      end
      WR: begin
        mem_w   = 1'b1;
        mem_d   = wdata_q;
        state_d = RESP;
      end
      RMW_RD:    state_d = RMW_MERGE;
      RMW_MERGE: begin
        for (int i = 0; i < NBYTE; i++) begin
          merge_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_q[8*i +: 8];
        end
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_w   = 1'b1;
        mem_d   = merge_q;
        state_d = RESP;
      end
      RESP: begin
        req_ready = resp_ready;
        if (resp_ready) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase

    // No request is taken while reset is held, even though the state is IDLE.
    if (!rst_n) req_ready = 1'b0;

    // Accepted request: capture it and route on direction and byte mask.
    if (req_valid && req_ready) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
      we_d    = req_we;
      rdata_d = '0;
      if (!req_we)         state_d = RD_ISSUE;
      else if (&req_be)    state_d = WR;
      else if (~|req_be)   state_d = RESP;
      else                 state_d = RMW_RD;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
      mem_d_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      mem_d_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural synchronous memory.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [15:0] mem_a;
  logic        mem_w;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state.
  logic [31:0] mem [0:65535];
  int          wr_cnt  = 0;
  logic [31:0] last_wd = '0;

  dmem_access_ctrl #(.WORD(32), .ADDR(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_a      (mem_a),
    .mem_w      (mem_w),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write on mem_w, otherwise register the addressed word.
  always @(posedge clk) begin
    if (mem_w) begin
      mem[mem_a] = mem_d;
      wr_cnt     = wr_cnt + 1;
      last_wd    = mem_d;
    end else begin
      mem_q <= mem[mem_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction; lat counts edges from acceptance (inclusive)
  // until resp_valid is seen, rd is the response data.
  task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, w0;
    logic [31:0] rd;

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_w", 32'(mem_w), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    rst_n = 1'b1;
    #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Full write then read.
    w0 = wr_cnt;
    do_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'b1111, lat, rd);
    check("fw_latency", 32'(lat), 32'd2);
    check("fw_rdata", rd, 32'd0);
    check("fw_pulses", 32'(wr_cnt - w0), 32'd1);
    check("fw_mem", mem[16'h0010], 32'hDEADBEEF);
    w0 = wr_cnt;
    do_req(1'b0, 16'h0010, 32'h0, 4'b1111, lat, rd);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rd, 32'hDEADBEEF);
    check("rd_pulses", 32'(wr_cnt - w0), 32'd0);

    // Partial write merged over existing contents.
    do_req(1'b1, 16'h0020, 32'h11223344, 4'b1111, lat, rd);
    w0 = wr_cnt;
    do_req(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, lat, rd);
    check("pw_latency", 32'(lat), 32'd4);
    check("pw_pulses", 32'(wr_cnt - w0), 32'd1);
    check("pw_mem_d", last_wd, 32'h11BB33DD);
    check("pw_rdata", rd, 32'd0);
    do_req(1'b0, 16'h0020, 32'h0, 4'b0000, lat, rd);
    check("pw_readback", rd, 32'h11BB33DD);

    // Write with no byte enables.
    do_req(1'b1, 16'h0030, 32'hCAFEF00D, 4'b1111, lat, rd);
    w0 = wr_cnt;
    do_req(1'b1, 16'h0030, 32'h12345678, 4'b0000, lat, rd);
    check("be0_latency", 32'(lat), 32'd1);
    check("be0_pulses", 32'(wr_cnt - w0), 32'd0);
    check("be0_mem", mem[16'h0030], 32'hCAFEF00D);
    check("be0_rdata", rd, 32'd0);

    // Backpressure, ignored requests while stalled, then back-to-back accept.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_be = 4'hF;
    @(posedge clk);
    #1 req_addr = 16'h0020;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check("bp_first_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1 check("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 begin req_valid = 1'b0; resp_ready = 1'b0; end
    @(negedge clk);
    check("b2b_accepted_addr", 32'(mem_a), 32'h0020);
    check("b2b_resp_dropped", 32'(resp_valid), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'd3);
    check("b2b_rdata", resp_rdata, 32'h11BB33DD);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    // Reset during the merge step of a partial write.
    do_req(1'b1, 16'h0040, 32'h55667788, 4'b1111, lat, rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040;
    req_wdata = 32'h99AABBCC; req_be = 4'b0011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rmw_rst_mem_w", 32'(mem_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rmw_rst_req_ready", 32'(req_ready), 32'd1);
    check("rmw_rst_pulses", 32'(wr_cnt - w0), 32'd0);
    check("rmw_rst_mem", mem[16'h0040], 32'h55667788);
    do_req(1'b0, 16'h0040, 32'h0, 4'b0000, lat, rd);
    check("rmw_rst_readback", rd, 32'h55667788);

    // Boundary addresses.
    do_req(1'b1, 16'h0000, 32'h01020304, 4'b1111, lat, rd);
    do_req(1'b1, 16'hFFFF, 32'hF0E0D0C0, 4'b1111, lat, rd);
    do_req(1'b0, 16'h0000, 32'h0, 4'b0000, lat, rd);
    check("bnd_low", rd, 32'h01020304);
    do_req(1'b0, 16'hFFFF, 32'h0, 4'b0000, lat, rd);
    check("bnd_high", rd, 32'hF0E0D0C0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
